// File: rtl/ps2_kbd_ctrl_if.sv
// Handshake bundle between the PS/2 receiver, the keyboard controller and the game logic.
// Latency: none (wires only).
// Backpressure: rx_en is the receiver gate and rd is the consumer pop strobe.
interface ps2_kbd_ctrl_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       rd;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       ovf_clr;

  // Receiver and game-logic side: drives bytes and pops, observes events and flags.
  modport master (
    output rx_done_tick, rx_data, rd, ovf_clr,
    input  rx_en, key_code, key_ext, key_break, empty, full, overflow
  );

  // Controller side.
  modport slave (
    input  rx_done_tick, rx_data, rd, ovf_clr,
    output rx_en, key_code, key_ext, key_break, empty, full, overflow
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// Scan-byte decoder (E0/F0 prefixes + code) feeding a show-ahead key-event FIFO.
// Latency: code byte tick in cycle N is written at the edge ending N; head visible in N+1.
// Backpressure: rx_en = ~full; events that arrive while full without a pop are dropped and set overflow.
// Optional prefix watchdog enabled by defining PS2_KBD_TIMEOUT_EN.
module ps2_kbd_ctrl #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              reset,
  ps2_kbd_ctrl_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  evt_t          mem_q [DEPTH];

  evt_t          evt;
  evt_t          head;
  logic          push_req;
  logic          push_ok;
  logic          do_pop;
  logic          drop;
  logic          is_e0;
  logic          is_f0;
  logic          tmo_hit;

`ifdef PS2_KBD_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES) > 18) ? $clog2(TIMEOUT_CYCLES) : 18;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: idle at 0, restarted by every byte, counts while a prefix is pending.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q + TW'(1);
    if (state_q == IDLE || bus.rx_done_tick || tmo_hit) begin
      tmo_cnt_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign is_e0 = (bus.rx_data == 8'hE0);
  assign is_f0 = (bus.rx_data == 8'hF0);

  // Decoder next state: prefixes only move the FSM, any other byte emits an event.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    evt.ext  = 1'b0;
    evt.brk  = 1'b0;
    evt.code = bus.rx_data;
    if (bus.rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (is_e0)      state_d = EXT;
          else if (is_f0) state_d = BRK;
          else            push_req = 1'b1;
        end
        EXT: begin
          if (is_f0)      state_d = EXT_BRK;
          else if (!is_e0) begin
            push_req = 1'b1;
            evt.ext  = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          // Stray prefixes after F0 are absorbed.
          if (!is_e0 && !is_f0) begin
            push_req = 1'b1;
            evt.brk  = 1'b1;
            state_d  = IDLE;
          end
        end
        default: begin
          if (!is_e0 && !is_f0) begin
            push_req = 1'b1;
            evt.ext  = 1'b1;
            evt.brk  = 1'b1;
            state_d  = IDLE;
          end
        end
      endcase
    end else if (tmo_hit) begin
      // Abandoned prefix: drop it silently.
      state_d = IDLE;
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    do_pop     = bus.rd && !empty_q;
    push_ok    = push_req && (!full_q || bus.rd);
    drop       = push_req && full_q && !bus.rd;
    wr_ptr_d   = wr_ptr_q + PW'(push_ok);
    rd_ptr_d   = rd_ptr_q + PW'(do_pop);
    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    overflow_d = overflow_q;
    if (bus.ovf_clr) overflow_d = 1'b0;
    if (drop)        overflow_d = 1'b1;
  end

  // State, pointer and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Event storage; contents are not reset, the flags make stale entries invisible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= evt;
  end

  // Head is forced to zero while empty so outputs are clean out of reset.
  assign head          = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.key_code  = head.code;
  assign bus.key_ext   = head.ext;
  assign bus.key_break = head.brk;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = overflow_q;
  assign bus.rx_en     = ~full_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: stimulus queues expected events, a monitor pops and compares.
// Latency: head checked one cycle after each code byte.
// Backpressure: fill/overflow/simultaneous pop-push exercised with the monitor held off.
module tb_ps2_kbd_ctrl;
  localparam int DEPTH = 8;
  localparam int TO    = 40;

  logic clk;
  logic reset;
  ps2_kbd_ctrl_if bus ();

  ps2_kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q [$];
  logic drain_en = 1'b0;
  logic pop_req  = 1'b0;
  logic rd_force = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the head whenever draining (or a single pop is requested) and compares it.
  initial begin
    logic [9:0] e;
    bus.rd = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!bus.empty && (drain_en || pop_req)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none",
                   {bus.key_ext, bus.key_break, bus.key_code});
        end else begin
          e = exp_q.pop_front();
          check("event", {22'd0, bus.key_ext, bus.key_break, bus.key_code}, {22'd0, e});
        end
        bus.rd  = 1'b1;
        pop_req = 1'b0;
      end else begin
        bus.rd = rd_force;
      end
    end
  end

  // One byte tick, held across exactly one rising edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  // Code byte with an expected event; also checks empty falls exactly one cycle later.
  task automatic send_evt(input logic ext, input logic brk, input logic [7:0] b);
    exp_q.push_back({ext, brk, b});
    @(negedge clk);
    check("empty_before_code", bus.empty, 1'b1);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    check("empty_fall", bus.empty, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.empty) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 200, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset            = 1'b1;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.ovf_clr      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_full", bus.full, 1'b0);
    check("rst_rx_en", bus.rx_en, 1'b1);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_key", {bus.key_ext, bus.key_break, bus.key_code}, 10'h000);
    reset = 1'b0;
    drain_en = 1'b1;

    // Basic make / break / extended forms and malformed prefixes.
    send_evt(1'b0, 1'b0, 8'h1C);
    send(8'hF0); send_evt(1'b0, 1'b1, 8'h1C);
    send(8'hE0); send_evt(1'b1, 1'b0, 8'h75);
    send(8'hE0); send(8'hF0); send_evt(1'b1, 1'b1, 8'h75);
    send(8'hF0); send(8'hE0); send(8'hF0); send_evt(1'b0, 1'b1, 8'h1C);
    send(8'hE0); send(8'hE0); send_evt(1'b1, 1'b0, 8'h6B);
    send(8'hE0); send(8'hF0); send(8'hE0); send_evt(1'b1, 1'b1, 8'h74);
    send_evt(1'b0, 1'b0, 8'hAA);
    send_evt(1'b0, 1'b0, 8'hE1);
    wait_drain();

    // Fill to DEPTH with no reads.
    drain_en = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      exp_q.push_back({2'b00, 8'(i)});
      send(8'(i));
    end
    check("full_set", bus.full, 1'b1);
    check("rx_en_low", bus.rx_en, 1'b0);
    check("ovf_before_drop", bus.overflow, 1'b0);
    send(8'h99);
    check("ovf_on_drop", bus.overflow, 1'b1);
    check("full_after_drop", bus.full, 1'b1);
    // Clear and drop in the same cycle: flag stays set.
    @(negedge clk);
    bus.rx_data = 8'h98; bus.rx_done_tick = 1'b1; bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0; bus.ovf_clr = 1'b0;
    check("ovf_clr_vs_drop", bus.overflow, 1'b1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", bus.overflow, 1'b0);

    // Simultaneous pop and push while full.
    exp_q.push_back({2'b00, 8'h09});
    @(negedge clk);
    bus.rx_data = 8'h09; bus.rx_done_tick = 1'b1; pop_req = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    check("full_after_pop_push", bus.full, 1'b1);
    check("ovf_after_pop_push", bus.overflow, 1'b0);
    drain_en = 1'b1;
    wait_drain();
    check("empty_after_drain", bus.empty, 1'b1);
    check("rx_en_after_drain", bus.rx_en, 1'b1);

    // rd together with a push while empty: rd ignored, one entry remains.
    drain_en = 1'b0;
    rd_force = 1'b1;
    exp_q.push_back({2'b00, 8'h33});
    send(8'h33);
    rd_force = 1'b0;
    @(negedge clk);
    check("rd_while_empty", bus.empty, 1'b0);
    drain_en = 1'b1;
    wait_drain();

    // Abandoned E0 prefix.
    send(8'hE0);
    repeat (TO + 2) @(negedge clk);
`ifdef PS2_KBD_TIMEOUT_EN
    send_evt(1'b0, 1'b0, 8'h1C);
`else
    send_evt(1'b1, 1'b0, 8'h1C);
`endif
    wait_drain();

    // Reset mid-sequence with a stored event: both discarded.
    drain_en = 1'b0;
    send(8'h55);
    send(8'hF0);
    check("pre_reset_nonempty", bus.empty, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_empty", bus.empty, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    drain_en = 1'b1;
    send_evt(1'b0, 1'b0, 8'h1C);
    wait_drain();
    check("scoreboard_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Keyboard-side controller placed directly behind the PS/2 receiver. It gates the receiver's `rx_en` and assembles raw scan bytes (`E0`, `F0` prefixes plus code byte) into single key events. Events are queued in a small show-ahead FIFO for the game logic. An optional watchdog abandons a prefix sequence that never completes.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of two, minimum 2.
- `TIMEOUT_CYCLES`, 200000: prefix watchdog limit in `clk` cycles (2 ms at 100 MHz). Used only with `PS2_KBD_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx_done_tick` in 1: one-cycle strobe from the receiver; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `rx_en` out 1: receive enable to the receiver; equals `~full`.
- `rd` in 1: pop the head event. Ignored when `empty`.
- `key_code` out 8: head event code byte.
- `key_ext` out 1: head event was preceded by `E0`.
- `key_break` out 1: head event is a release (preceded by `F0`).
- `empty` out 1: FIFO holds no events.
- `full` out 1: FIFO holds `DEPTH` events.
- `overflow` out 1: sticky flag; an event was dropped.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- Decoder FSM states: `IDLE`, `EXT` (`E0` seen), `BRK` (`F0` seen), `EXT_BRK` (`E0 F0` seen).
- Transitions, evaluated only on `rx_done_tick`:
  - `IDLE`: `E0` goes to `EXT`; `F0` goes to `BRK`; any other byte pushes `{ext=0, brk=0, code}` and stays in `IDLE`.
  - `EXT`: `F0` goes to `EXT_BRK`; `E0` stays in `EXT`; any other byte pushes `{1, 0, code}` and goes to `IDLE`.
  - `BRK`: `E0` or `F0` goes back to `BRK` (malformed input, absorbed); any other byte pushes `{0, 1, code}` and goes to `IDLE`.
  - `EXT_BRK`: `E0` or `F0` stays; any other byte pushes `{1, 1, code}` and goes to `IDLE`.
- All non-prefix bytes (including `AA`, `FA`, `E1`) are passed through as codes.
- FIFO:
  - 10-bit entries `{ext, brk, code}`, show-ahead. Outputs show `mem[rd_ptr]`; their value is don't-care while `empty`.
  - Read and write pointers are `log2(DEPTH)+1` bits wide and wrap naturally.
  - `full` when the pointer MSBs differ and the low bits are equal; `empty` when the pointers are equal.
- A push is accepted when `!full`, or when `full && rd` in the same cycle (simultaneous pop and push, count unchanged).
- A push that is not accepted is dropped, and `overflow` is set. This can only happen when a frame was already in flight as `full` rose.
- `ovf_clr` and a new drop in the same cycle: the flag stays set.
- `rd` and a push in the same cycle while `empty`: the push is accepted, the `rd` is ignored, and the count becomes 1.

## Timing
- Reset values:
  - FSM `IDLE`, pointers 0, `overflow` 0, `empty` 1, `full` 0, `rx_en` 1.
  - `key_*` outputs are 0 (the memory is not cleared).
- Latency: event bytes go from `rx_done_tick` in cycle N to the FIFO write at the edge ending N. `empty` falls and the head is visible in cycle N+1.
- A prefix byte produces no push; only the FSM state changes at the edge ending N.
- `rd` in cycle M: the next entry is on the outputs in M+1. `full` and `empty` are registered and update in the same cycle as the pointers.
- `rx_en` is combinational from the `full` register.
- Reset asserted mid-sequence: the FSM, pointers and flags return to reset values immediately, and any partial prefix is discarded.

## Configuration
- `PS2_KBD_TIMEOUT_EN` defined:
  - An 18-bit-or-wider counter runs while the FSM is in a non-`IDLE` state.
  - It restarts on every `rx_done_tick`.
  - When it reaches `TIMEOUT_CYCLES - 1`, the FSM returns to `IDLE` at the next edge and no event is pushed.
  - The counter is held at 0 in `IDLE`.
- Not defined: no counter is present, and the FSM waits in a prefix state indefinitely.

## Test plan
- Bytes `1C`: one event `{0,0,1C}`. Then `F0 1C`: event `{0,1,1C}`. `empty` falls one cycle after each code tick.
- `E0 75` then `E0 F0 75`: events `{1,0,75}` and `{1,1,75}`, with no event emitted for any prefix.
- Push 8 codes with `DEPTH=8` and no reads: `full=1`, `rx_en=0`. A 9th tick is dropped with `overflow=1`. Pop all 8 in order `1..8`, then `empty=1`, `rx_en=1`. `ovf_clr` clears `overflow`.
- While `full`, a tick with `rd` in the same cycle: count stays 8, the new event lands at the tail, and `overflow` stays 0.
- `E0`, then wait `TIMEOUT_CYCLES` cycles, then `1C`:
  - With `PS2_KBD_TIMEOUT_EN`: result is `{0,0,1C}`.
  - Without it: result is `{1,0,1C}`.
- `reset` pulsed after `F0`, then `1C`: result is `{0,0,1C}`, and the FIFO was emptied by the reset.
